vga_sram_pattern_writer: RTL and testbench
==========================================

# vga_sram_pattern_writer

Fills the SRAM framebuffer with a fixed test pattern after reset, then raises `pattern_done` to hand the SRAM to the VGA display stage. It sits directly upstream of the SRAM display reader. It owns the SRAM address, data and strobes until done. The top level muxes the address onto the SRAM pins on `pattern_done`.

## Interface
- `ADDR_BITS`, 20, SRAM address width
- `DATA_BITS`, 16, SRAM data width; the pixel is packed as `{red[3:0], green[3:0], blue[3:0], 4'b0}` in bits [15:0]
- `H_VISIBLE`, 640, pixels per row
- `V_VISIBLE`, 480, rows per frame
- `clk` in 1: the single clock for the block.
- `reset` in 1: synchronous, active-high reset.
- `sram_addr` out ADDR_BITS: write address (read address in the verify pass).
- `sram_data_out` out DATA_BITS: write data.
- `sram_data_oe` out 1: when 1, the top level drives `sram_data_out` onto the SRAM data bus.
- `sram_we_n` out 1: active-low write strobe.
- `sram_oe_n` out 1: active-low SRAM output enable.
- `sram_data_in` in DATA_BITS: readback data; used only with the verify feature.
- `pattern_done` out 1: high and held once the fill (and verify, if compiled in) completes.
- `pattern_err` out 1: sticky readback mismatch flag; always 0 when verify is compiled out.

## Operation
- All outputs are registered.
- Reset values: `sram_addr`=0, `sram_data_out`=0, `sram_data_oe`=0, `sram_we_n`=1, `sram_oe_n`=1, `pattern_done`=0, `pattern_err`=0.
- Counters:
  - `column` is 10 bits and runs 0..H_VISIBLE-1.
  - `row` is 10 bits and runs 0..V_VISIBLE-1.
  - The linear address is an ADDR_BITS counter incremented once per pixel, so it always equals row*H_VISIBLE+column. No multiplier.
- Pattern function: red=column[7:4], green=row[7:4], blue=column[3:0]^row[3:0].
- State machine:
  - WR_SETUP: drive addr and data, `sram_data_oe`=1, `sram_we_n`=1. Next state is WR_PULSE.
  - WR_PULSE: `sram_we_n`=0 with addr and data held. Then advance the pixel. After the last pixel, go to RD_ADDR (verify) or DONE; otherwise go to WR_SETUP.
  - RD_ADDR (verify only): `sram_data_oe`=0, `sram_oe_n`=0, drive addr. Next state is RD_CHECK.
  - RD_CHECK (verify only): compare `sram_data_in` with the expected pixel and set `pattern_err` on mismatch. Advance the pixel. After the last pixel go to DONE, otherwise RD_ADDR.
  - DONE: `pattern_done`=1, `sram_we_n`=1, `sram_oe_n`=1, `sram_data_oe`=0, `sram_addr`=0. This state is terminal until reset.
- Wrap: column wraps to 0 and row increments when column==H_VISIBLE-1. The last pixel is (H_VISIBLE-1, V_VISIBLE-1). The counters reset to 0 between the write pass and the verify pass.
- A reset mid-fill or mid-verify aborts immediately. All outputs return to their reset values, and the fill restarts at pixel 0 on the first cycle after reset deasserts.
- H_VISIBLE*V_VISIBLE ≤ 2^ADDR_BITS is required. The counters never exceed this bound.

## Timing
- Cycle 0 is the first rising edge with `reset` low.
- Pixel n uses WR_SETUP at cycle 2n and WR_PULSE at cycle 2n+1.
- Address and data are stable for one full cycle before and during the `sram_we_n` low cycle. `sram_data_oe` stays high across the whole write pass.
- With N=H_VISIBLE*V_VISIBLE:
  - Without verify, `pattern_done` rises at cycle 2N (614400 for the defaults).
  - With verify, the read of pixel n is RD_ADDR at 2N+2n and RD_CHECK at 2N+2n+1. `pattern_done` rises at 4N.
- Read latency: the SRAM must deliver data within one cycle. `sram_data_in` is sampled on the RD_CHECK edge.
- `pattern_err` updates on the cycle after RD_CHECK and stays set until reset.

## Configuration
- Macro: `VGA_SRAM_PATTERN_VERIFY_EN`.
- Defined: the RD_ADDR and RD_CHECK pass is compiled in, and `pattern_err` is live.
- Undefined: WR_PULSE of the last pixel goes directly to DONE, `pattern_err` is tied to 0, and `sram_oe_n` stays 1.

## Structure
- Shared header `vga_sram_defs.v` holds:
  - the state encodings;
  - the pixel field positions (RED_MSB=15, GREEN_MSB=11, BLUE_MSB=7);
  - default frame dimensions, shared with the display reader.
- Sub-module `vga_test_pattern`: combinational (column, row) → pixel word. The writer and the bench's expected-value model both instantiate it.

## Test plan
- Small frame with H_VISIBLE=4, V_VISIBLE=2, reset released:
  - write sequence is addr 0..7, each with one `sram_we_n` low cycle at odd cycles 1..15;
  - `pattern_done` rises at cycle 16.
- Pattern value: pixel (column 0x35, row 0x12) at defaults → address 0x2D35, data 0x3170.
- Reset asserted at cycle 7 of the small frame: outputs go to reset values the next cycle, and after release the addr restarts at 0. `pattern_done` rises 16 cycles after release.
- Verify defined, SRAM model correct: `pattern_done` at cycle 32 (small frame), `pattern_err`=0, and `sram_data_oe`=0 whenever `sram_oe_n`=0.
- Verify defined, SRAM model corrupts addr 5: `pattern_err` rises after the addr-5 RD_CHECK and stays set. `pattern_done` still rises at 32.
- In DONE, hold for 100 cycles: `sram_we_n`=1, `sram_oe_n`=1, `sram_data_oe`=0, `sram_addr`=0, and `pattern_done` stays steady at 1.

Source files
------------

// File: rtl/vga_sram_pattern_writer_pkg.sv
// Shared definitions for the SRAM test-pattern writer: state encodings,
// pixel field positions and default frame dimensions shared with the display reader.
package vga_sram_pattern_writer_pkg;

    localparam int DEFAULT_H_VISIBLE = 640;
    localparam int DEFAULT_V_VISIBLE = 480;
    localparam int COORD_BITS        = 10;
    localparam int PIXEL_BITS        = 16;

    localparam int RED_MSB   = 15;
    localparam int GREEN_MSB = 11;
    localparam int BLUE_MSB  = 7;

    typedef enum logic [2:0] {
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_RD_ADDR,
        ST_RD_CHECK,
        ST_DONE
    } state_e;

endpackage

// File: rtl/vga_sram_pattern_writer_test_pattern.sv
// Combinational test-pattern generator: (column, row) -> packed 4:4:4 pixel word.
// Only the low 8 bits of each coordinate contribute to the pattern.
module vga_sram_pattern_writer_test_pattern
    import vga_sram_pattern_writer_pkg::*;
(
    input  logic [7:0]            column_i,
    input  logic [7:0]            row_i,
    output logic [PIXEL_BITS-1:0] pixel_o
);

    always_comb begin
        // NOTE: assign a default first so every path drives pixel_o and no latch is inferred.
        pixel_o                   = '0;
        pixel_o[RED_MSB   -: 4]   = column_i[7:4];
        pixel_o[GREEN_MSB -: 4]   = row_i[7:4];
        pixel_o[BLUE_MSB  -: 4]   = column_i[3:0] ^ row_i[3:0];
    end

endmodule

// File: rtl/vga_sram_pattern_writer.sv
// Fills the SRAM framebuffer with a test pattern after reset, then raises pattern_done.
// Optional readback pass compiled in with `define VGA_SRAM_PATTERN_VERIFY_EN.
module vga_sram_pattern_writer
    import vga_sram_pattern_writer_pkg::*;
#(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16,
    parameter int H_VISIBLE = DEFAULT_H_VISIBLE,
    parameter int V_VISIBLE = DEFAULT_V_VISIBLE
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [DATA_BITS-1:0] sram_data_out,
    output logic                 sram_data_oe,
    output logic                 sram_we_n,
    output logic                 sram_oe_n,
    input  logic [DATA_BITS-1:0] sram_data_in,
    output logic                 pattern_done,
    output logic                 pattern_err
);

    if (H_VISIBLE * V_VISIBLE > 2 ** ADDR_BITS) begin : g_frame_too_large
        $error("frame does not fit in the SRAM address space");
    end

    localparam logic [COORD_BITS-1:0] LAST_COL = COORD_BITS'(H_VISIBLE - 1);
    localparam logic [COORD_BITS-1:0] LAST_ROW = COORD_BITS'(V_VISIBLE - 1);

`ifdef VGA_SRAM_PATTERN_VERIFY_EN
    localparam state_e AFTER_WRITE = ST_RD_ADDR;
`else
    localparam state_e AFTER_WRITE = ST_DONE;
`endif

    state_e                 state_q;
    logic [COORD_BITS-1:0]  column_q, column_d;
    logic [COORD_BITS-1:0]  row_q, row_d;
    logic [ADDR_BITS-1:0]   lin_q, lin_d;
    logic                   last_pixel;

    logic [ADDR_BITS-1:0]   addr_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   data_oe_q, we_n_q, oe_n_q, done_q;
    logic [PIXEL_BITS-1:0]  pixel_word;
    logic [DATA_BITS-1:0]   pixel_data;

    vga_sram_pattern_writer_test_pattern u_pattern (
        .column_i (column_q[7:0]),
        .row_i    (row_q[7:0]),
        .pixel_o  (pixel_word)
    );

    assign pixel_data = DATA_BITS'(pixel_word);

    // Linear address tracks row*H_VISIBLE+column by incrementing alongside the raster counters.
    always_comb begin
        column_d   = column_q + 1'b1;
        row_d      = row_q;
        lin_d      = lin_q + 1'b1;
        last_pixel = 1'b0;
        if (column_q == LAST_COL) begin
            column_d   = '0;
            row_d      = row_q + 1'b1;
            last_pixel = (row_q == LAST_ROW);
        end
    end

`ifdef VGA_SRAM_PATTERN_VERIFY_EN
    logic err_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_WR_SETUP;
            column_q  <= '0;
            row_q     <= '0;
            lin_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            data_oe_q <= 1'b0;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            done_q    <= 1'b0;
`ifdef VGA_SRAM_PATTERN_VERIFY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_WR_SETUP: begin
                    addr_q    <= lin_q;
                    data_q    <= pixel_data;
                    data_oe_q <= 1'b1;
                    we_n_q    <= 1'b1;
                    oe_n_q    <= 1'b1;
                    state_q   <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    we_n_q <= 1'b0;
                    if (last_pixel) begin
                        column_q <= '0;
                        row_q    <= '0;
                        lin_q    <= '0;
                        state_q  <= AFTER_WRITE;
                    end else begin
                        column_q <= column_d;
                        row_q    <= row_d;
                        lin_q    <= lin_d;
                        state_q  <= ST_WR_SETUP;
                    end
                end
`ifdef VGA_SRAM_PATTERN_VERIFY_EN
                ST_RD_ADDR: begin
                    addr_q    <= lin_q;
                    data_oe_q <= 1'b0;
                    we_n_q    <= 1'b1;
                    oe_n_q    <= 1'b0;
                    state_q   <= ST_RD_CHECK;
                end
                ST_RD_CHECK: begin
                    if (sram_data_in != pixel_data) begin
                        err_q <= 1'b1;
                    end
                    if (last_pixel) begin
                        column_q <= '0;
                        row_q    <= '0;
                        lin_q    <= '0;
                        state_q  <= ST_DONE;
                    end else begin
                        column_q <= column_d;
                        row_q    <= row_d;
                        lin_q    <= lin_d;
                        state_q  <= ST_RD_ADDR;
                    end
                end
`endif
                ST_DONE: begin
                    addr_q    <= '0;
                    data_oe_q <= 1'b0;
                    we_n_q    <= 1'b1;
                    oe_n_q    <= 1'b1;
                    done_q    <= 1'b1;
                end
                default: state_q <= ST_WR_SETUP;
            endcase
        end
    end

    assign sram_addr     = addr_q;
    assign sram_data_out = data_q;
    assign sram_data_oe  = data_oe_q;
    assign sram_we_n     = we_n_q;
    assign sram_oe_n     = oe_n_q;
    assign pattern_done  = done_q;

`ifdef VGA_SRAM_PATTERN_VERIFY_EN
    assign pattern_err = err_q;
`else
    logic data_in_unused;
    assign data_in_unused = ^sram_data_in;
    assign pattern_err    = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sram_pattern_writer.sv
// Bench for vga_sram_pattern_writer: a small 4x2 frame checked every cycle against
// timing rules, plus a default-size frame checked up to a known mid-frame pixel.
module tb_vga_sram_pattern_writer;

    localparam int SH = 4;
    localparam int SV = 2;
    localparam int SN = SH * SV;
    localparam int DH = 640;

`ifdef VGA_SRAM_PATTERN_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s = 1'b1;
    logic        rst_d = 1'b1;

    logic [19:0] s_addr, d_addr;
    logic [15:0] s_dout, d_dout, s_din, d_din;
    logic        s_doe, s_we_n, s_oe_n, s_done, s_err;
    logic        d_doe, d_we_n, d_oe_n, d_done, d_err;

    vga_sram_pattern_writer #(.H_VISIBLE(SH), .V_VISIBLE(SV)) u_small (
        .clk           (clk),
        .reset         (rst_s),
        .sram_addr     (s_addr),
        .sram_data_out (s_dout),
        .sram_data_oe  (s_doe),
        .sram_we_n     (s_we_n),
        .sram_oe_n     (s_oe_n),
        .sram_data_in  (s_din),
        .pattern_done  (s_done),
        .pattern_err   (s_err)
    );

    vga_sram_pattern_writer u_dflt (
        .clk           (clk),
        .reset         (rst_d),
        .sram_addr     (d_addr),
        .sram_data_out (d_dout),
        .sram_data_oe  (d_doe),
        .sram_we_n     (d_we_n),
        .sram_oe_n     (d_oe_n),
        .sram_data_in  (d_din),
        .pattern_done  (d_done),
        .pattern_err   (d_err)
    );

    // Behavioural SRAM for the small frame, with an optional corrupted address.
    logic [15:0] mem_s [SN];
    int          corrupt_addr = -1;
    logic [15:0] corrupt_mask = 16'h0001;

    always @(posedge clk) begin
        if (!s_we_n && s_addr < 20'(SN)) mem_s[s_addr[2:0]] <= s_dout;
    end

    assign s_din = (!s_oe_n && s_addr < 20'(SN))
                 ? (mem_s[s_addr[2:0]] ^ ((int'(s_addr) == corrupt_addr) ? corrupt_mask : 16'h0000))
                 : 16'h0000;
    assign d_din = 16'h0000;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pix(input int col, input int row);
        logic [9:0] c = 10'(col);
        logic [9:0] r = 10'(row);
        return {c[7:4], r[7:4], c[3:0] ^ r[3:0], 4'h0};
    endfunction

    // Control word: {data_oe, we_n, oe_n, done, err}
    task automatic check_small_reset(input string tag);
        check({tag, " addr"}, 64'(s_addr), 64'd0);
        check({tag, " data"}, 64'(s_dout), 64'd0);
        check({tag, " ctl"}, 64'({s_doe, s_we_n, s_oe_n, s_done, s_err}), 64'(5'b01100));
    endtask

    task automatic check_small_cycle(input int c, input int corrupt);
        int         w = 2 * SN;
        int         k;
        logic [4:0] ctl;
        logic [19:0] addr;
        if (c < w) begin
            k    = c / 2;
            addr = 20'(k);
            ctl  = {1'b1, (c % 2 == 0), 1'b1, 1'b0, 1'b0};
            check($sformatf("small c%0d data", c), 64'(s_dout), 64'(pix(k % SH, k / SH)));
        end else if (VERIFY && c < 2 * w) begin
            k    = (c - w) / 2;
            addr = 20'(k);
            ctl  = {1'b0, 1'b1, 1'b0, 1'b0, (corrupt >= 0 && c >= w + 2 * corrupt + 1)};
        end else begin
            addr = 20'd0;
            ctl  = {1'b0, 1'b1, 1'b1, 1'b1, (VERIFY && corrupt >= 0)};
        end
        check($sformatf("small c%0d addr", c), 64'(s_addr), 64'(addr));
        check($sformatf("small c%0d ctl", c), 64'({s_doe, s_we_n, s_oe_n, s_done, s_err}), 64'(ctl));
    endtask

    task automatic run_small(input int corrupt, input int reset_at, input int extra);
        int last_c = (VERIFY ? 4 * SN : 2 * SN) + extra;
        rst_s        = 1'b1;
        corrupt_addr = corrupt;
        corrupt_mask = 16'($urandom_range(1, 16'hFFFF));
        @(posedge clk); #1;
        check_small_reset("reset");
        rst_s = 1'b0;
        for (int c = 0; c <= last_c; c++) begin
            if (c == reset_at) rst_s = 1'b1;
            @(posedge clk); #1;
            if (c == reset_at) begin
                check_small_reset($sformatf("abort c%0d", c));
                return;
            end
            check_small_cycle(c, corrupt);
        end
        for (int a = 0; a < SN; a++)
            check($sformatf("mem %0d", a), 64'(mem_s[a]), 64'(pix(a % SH, a / SH)));
    endtask

    typedef struct {
        int          col;
        int          row;
        logic [19:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int c;
        int target;
        tbl = '{
            '{0,    0,    20'd0,     16'h0000},
            '{15,   0,    20'd15,    16'h00F0},
            '{16,   0,    20'd16,    16'h1000},
            '{639,  0,    20'd639,   16'h70F0},
            '{0,    1,    20'd640,   16'h0010},
            '{32,   16,   20'd10272, 16'h2100},
            '{5,    17,   20'd10885, 16'h0140},
            '{8'h35, 8'h12, 20'h2D35, 16'h3170}
        };

        // Small frame: clean run with a 100-cycle hold in DONE.
        run_small(-1, -1, 100);
        // Reset at cycle 7, then a clean restart.
        run_small(-1, 7, 0);
        run_small(-1, -1, 4);
        // Corrupted readback at address 5.
        run_small(5, -1, 10);
        // Randomized aborts and corruption targets.
        for (int i = 0; i < 4; i++) begin
            run_small(-1, int'($urandom_range(1, 2 * SN - 1)), 0);
            run_small(int'($urandom_range(0, SN - 1)), -1, 3);
        end

        // Default frame up to the last table pixel.
        @(posedge clk); #1;
        check("dflt reset addr", 64'(d_addr), 64'd0);
        check("dflt reset ctl", 64'({d_doe, d_we_n, d_oe_n, d_done, d_err}), 64'(5'b01100));
        rst_d = 1'b0;
        c = 0;
        for (int e = 0; e < 8; e++) begin
            target = 2 * int'(tbl[e].exp_addr) + 1;
            while (c <= target) begin
                @(posedge clk); #1;
                check($sformatf("dflt c%0d", c),
                      64'({d_addr, d_dout, d_doe, d_we_n}),
                      64'({20'(c / 2), pix((c / 2) % DH, (c / 2) / DH), 1'b1, (c % 2 == 0)}));
                c++;
            end
            check($sformatf("tbl %0d addr", e), 64'(d_addr), 64'(tbl[e].exp_addr));
            check($sformatf("tbl %0d data", e), 64'(d_dout), 64'(tbl[e].exp_data));
            check($sformatf("tbl %0d model", e), 64'(d_dout), 64'(pix(tbl[e].col, tbl[e].row)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
